// File: rtl/swap_sequencer_pkg.sv
// swap_sequencer_pkg: shared widths and FSM state encoding for the XCHG sequencer
package swap_sequencer_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_CAP  = 3'd3,
    S_WR_A = 3'd4,
    S_WR_B = 3'd5,
    S_DONE = 3'd6
  } state_t;
endpackage

// File: rtl/swap_sequencer_if.sv
// swap_sequencer_if: requester, register-file and swap-unit signals of the XCHG sequencer
interface swap_sequencer_if;
  import swap_sequencer_pkg::*;
  logic [1:0]        req;
  logic [ADDR_W-1:0] addr_a0;
  logic [ADDR_W-1:0] addr_b0;
  logic [ADDR_W-1:0] addr_a1;
  logic [ADDR_W-1:0] addr_b1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic              busy;
  logic              rf_re;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] swp_ain;
  logic [DATA_W-1:0] swp_bin;
  logic [DATA_W-1:0] swp_aout;
  logic [DATA_W-1:0] swp_bout;
  modport master (
    input  req, addr_a0, addr_b0, addr_a1, addr_b1, rf_rdata, swp_aout, swp_bout,
    output gnt, done, busy, rf_re, rf_raddr, rf_we, rf_waddr, rf_wdata, swp_ain, swp_bin
  );
  modport slave (
    output req, addr_a0, addr_b0, addr_a1, addr_b1, rf_rdata, swp_aout, swp_bout,
    input  gnt, done, busy, rf_re, rf_raddr, rf_we, rf_waddr, rf_wdata, swp_ain, swp_bin
  );
endinterface

// File: rtl/swap_sequencer_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter; pointer moves past whoever completed
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic [1:0] i_adv,
  output logic [1:0] o_gnt
);
  logic r_ptr;
  always_ff @(posedge clk)
    if (!rst_n) r_ptr <= 1'b0;
    else if (|i_adv) r_ptr <= i_adv[0];
  assign o_gnt = r_ptr ? (i_req[1] ? 2'b10 : {1'b0, i_req[0]})
                       : (i_req[0] ? 2'b01 : {i_req[1], 1'b0});
endmodule

// File: rtl/swap_sequencer.sv
// swap_sequencer: arbitrates two XCHG requesters and runs read-read-swap-write-write on the RF
module swap_sequencer
  import swap_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  swap_sequencer_if.master bus
);
  state_t            r_state, w_next;
  logic [1:0]        r_gnt, w_arb, w_done;
  logic [ADDR_W-1:0] r_addr_a, r_addr_b, w_sel_a, w_sel_b;
  logic [DATA_W-1:0] r_da, r_swp_a, r_swp_b;
  logic              w_accept;
  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (bus.req),
    .i_adv (w_done),
    .o_gnt (w_arb)
  );
  assign w_accept = (r_state == S_IDLE) && |w_arb;
  assign w_sel_a  = w_arb[1] ? bus.addr_a1 : bus.addr_a0;
  assign w_sel_b  = w_arb[1] ? bus.addr_b1 : bus.addr_b0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? ((w_sel_a == w_sel_b) ? S_DONE : S_RD_A) : S_IDLE;
      S_RD_A:  w_next = S_RD_B;
      S_RD_B:  w_next = S_CAP;
      S_CAP:   w_next = S_WR_A;
      S_WR_A:  w_next = S_WR_B;
      S_WR_B:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_da     <= '0;
      r_swp_a  <= '0;
      r_swp_b  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_gnt    <= w_arb;
        r_addr_a <= w_sel_a;
        r_addr_b <= w_sel_b;
      end else if (r_state == S_DONE) r_gnt <= '0;
      if (r_state == S_RD_B) r_da <= bus.rf_rdata;
      if (r_state == S_CAP) begin
        r_swp_a <= r_da;
        r_swp_b <= bus.rf_rdata;
      end
    end
  // strobes are gated by rst_n so a reset edge never commits a write or a done
  assign w_done       = (rst_n && r_state == S_DONE) ? r_gnt : '0;
  assign bus.done     = w_done;
  assign bus.gnt      = r_gnt;
  assign bus.busy     = r_state != S_IDLE;
  assign bus.rf_re    = rst_n && (r_state == S_RD_A || r_state == S_RD_B);
  assign bus.rf_raddr = (r_state == S_RD_A) ? r_addr_a : (r_state == S_RD_B) ? r_addr_b : '0;
  assign bus.rf_we    = rst_n && (r_state == S_WR_A || r_state == S_WR_B);
  assign bus.rf_waddr = (r_state == S_WR_A) ? r_addr_a : (r_state == S_WR_B) ? r_addr_b : '0;
  assign bus.rf_wdata = (r_state == S_WR_A) ? bus.swp_aout : (r_state == S_WR_B) ? bus.swp_bout : '0;
  assign bus.swp_ain  = r_swp_a;
  assign bus.swp_bin  = r_swp_b;
endmodule

// File: tb/tb_swap_sequencer.sv
// tb_swap_sequencer: table-driven XCHG vectors plus contention, drop, reset and back-to-back sequences
module tb_swap_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  swap_sequencer_if bus();
  swap_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mem [8];
  logic       tb_we = 1'b0;
  logic [2:0] tb_addr = '0;
  logic [7:0] tb_data = '0;
  int cyc = 0, n_re = 0, n_we = 0, n_ovl = 0;
  int total = 0, bad = 0;

  assign bus.swp_aout = bus.swp_bin;
  assign bus.swp_bout = bus.swp_ain;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rf_re) bus.rf_rdata <= mem[bus.rf_raddr];
    if (bus.rf_we) mem[bus.rf_waddr] <= bus.rf_wdata;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end
  always @(negedge clk) begin
    if (bus.rf_re) n_re <= n_re + 1;
    if (bus.rf_we) n_we <= n_we + 1;
    if (bus.rf_re && bus.rf_we) n_ovl <= n_ovl + 1;
  end

  typedef struct packed {
    logic [1:0] req;
    logic [2:0] a0, b0, a1, b1;
    logic [7:0] va, vb;
    logic [1:0] gnt;
    logic [3:0] lat, acc;
    logic [7:0] ea, eb;
  } vec_t;
  vec_t tv [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic rf_set(input logic [2:0] a, input logic [7:0] d);
    tb_addr = a;
    tb_data = d;
    tb_we = 1'b1;
    step();
    tb_we = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done == 2'b00 && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, lo, re0, we0;
    int acc [3];
    logic [2:0] a, b;
    vec_t v;
    tv[0] = '{2'b01, 3'd1, 3'd5, 3'd0, 3'd0, 8'h12, 8'hA7, 2'b01, 4'd6, 4'd2, 8'hA7, 8'h12};
    tv[1] = '{2'b10, 3'd0, 3'd0, 3'd3, 3'd3, 8'h5C, 8'h5C, 2'b10, 4'd1, 4'd0, 8'h5C, 8'h5C};
    tv[2] = '{2'b10, 3'd0, 3'd0, 3'd0, 3'd7, 8'h00, 8'hFF, 2'b10, 4'd6, 4'd2, 8'hFF, 8'h00};
    tv[3] = '{2'b11, 3'd2, 3'd6, 3'd4, 3'd0, 8'h3C, 8'hC3, 2'b01, 4'd6, 4'd2, 8'hC3, 8'h3C};
    tv[4] = '{2'b11, 3'd2, 3'd6, 3'd4, 3'd0, 8'h81, 8'h7E, 2'b10, 4'd6, 4'd2, 8'h7E, 8'h81};
    tv[5] = '{2'b01, 3'd7, 3'd7, 3'd0, 3'd0, 8'h99, 8'h99, 2'b01, 4'd1, 4'd0, 8'h99, 8'h99};
    tv[6] = '{2'b01, 3'd0, 3'd1, 3'd0, 3'd0, 8'h01, 8'h80, 2'b01, 4'd6, 4'd2, 8'h80, 8'h01};
    bus.req = '0;
    bus.addr_a0 = '0;
    bus.addr_b0 = '0;
    bus.addr_a1 = '0;
    bus.addr_b1 = '0;
    step();
    step();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_re_we", {bus.rf_re, bus.rf_we}, 0);
    chk("rst_swp", {bus.swp_ain, bus.swp_bin}, 0);
    chk("rst_addr_data", {bus.rf_raddr, bus.rf_waddr, bus.rf_wdata}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      v = tv[i];
      a = v.gnt[1] ? v.a1 : v.a0;
      b = v.gnt[1] ? v.b1 : v.b0;
      rf_set(a, v.va);
      rf_set(b, v.vb);
      bus.addr_a0 = v.a0;
      bus.addr_b0 = v.b0;
      bus.addr_a1 = v.a1;
      bus.addr_b1 = v.b1;
      bus.req = v.req;
      re0 = n_re;
      we0 = n_we;
      step();
      chk($sformatf("v%0d_gnt", i), bus.gnt, v.gnt);
      chk($sformatf("v%0d_busy", i), bus.busy, 1);
      wait_done(n);
      chk($sformatf("v%0d_lat", i), n + 1, v.lat);
      chk($sformatf("v%0d_done", i), bus.done, v.gnt);
      bus.req = '0;
      step();
      chk($sformatf("v%0d_idle", i), {bus.busy, bus.gnt, bus.done}, 0);
      chk($sformatf("v%0d_nre", i), n_re - re0, v.acc);
      chk($sformatf("v%0d_nwe", i), n_we - we0, v.acc);
      chk($sformatf("v%0d_mem_a", i), mem[a], v.ea);
      chk($sformatf("v%0d_mem_b", i), mem[b], v.eb);
      if (v.acc != 0) chk($sformatf("v%0d_swp_hold", i), {bus.swp_ain, bus.swp_bin}, {v.va, v.vb});
    end

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.addr_a0 = 3'd1;
    bus.addr_b0 = 3'd2;
    bus.addr_a1 = 3'd3;
    bus.addr_b1 = 3'd4;
    bus.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (bus.gnt == 2'b00 && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("t2_accept_timeout%0d", i), n < 20, 1);
      chk($sformatf("t2_gnt%0d", i), bus.gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
      wait_done(n);
      chk($sformatf("t2_done%0d", i), bus.done, (i % 2 == 1) ? 2'b10 : 2'b01);
      step();
      chk($sformatf("t2_done_one_cycle%0d", i), bus.done, 0);
    end
    bus.req = '0;
    step();
    chk("t2_idle", bus.busy, 0);

    rf_set(3'd2, 8'h11);
    rf_set(3'd6, 8'h22);
    bus.addr_a0 = 3'd2;
    bus.addr_b0 = 3'd6;
    bus.req = 2'b01;
    step();
    step();
    bus.req = '0;
    wait_done(n);
    chk("t4_done", bus.done, 2'b01);
    step();
    chk("t4_idle", bus.busy, 0);
    chk("t4_mem", {mem[2], mem[6]}, {8'h22, 8'h11});

    rf_set(3'd1, 8'h12);
    rf_set(3'd5, 8'hA7);
    bus.addr_a0 = 3'd1;
    bus.addr_b0 = 3'd5;
    bus.req = 2'b01;
    step();
    for (int k = 0; k < 4; k++) step();
    chk("t5_in_wr_b", {bus.rf_we, bus.rf_waddr}, {1'b1, 3'd5});
    rst_n = 1'b0;
    bus.req = '0;
    #1;
    chk("t5_rst_no_strobe", {bus.done, bus.rf_we}, 0);
    step();
    chk("t5_outs_zero", {bus.gnt, bus.done, bus.busy, bus.rf_re, bus.rf_we, bus.swp_ain, bus.swp_bin}, 0);
    chk("t5_mem_a_written", mem[1], 8'hA7);
    chk("t5_mem_b_unwritten", mem[5], 8'hA7);
    rst_n = 1'b1;
    step();
    chk("t5_stays_idle", bus.busy, 0);

    bus.addr_a0 = 3'd1;
    bus.addr_b0 = 3'd2;
    bus.req = 2'b01;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (bus.gnt == 2'b00 && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("t6_accept_timeout%0d", k), n < 20, 1);
      acc[k] = cyc;
      if (k < 2) begin
        n = 0;
        while (bus.busy && n < 20) begin
          step();
          n++;
        end
        lo = 0;
        while (!bus.busy && lo < 20) begin
          step();
          lo++;
        end
        chk($sformatf("t6_busy_low%0d", k), lo, 1);
      end
    end
    chk("t6_gap01", acc[1] - acc[0], 7);
    chk("t6_gap12", acc[2] - acc[1], 7);
    wait_done(n);
    chk("t6_last_done", bus.done, 2'b01);
    bus.req = '0;
    step();
    chk("re_we_overlap", n_ovl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
